// File: rtl/clock_mon_pkg.sv
// Shared definitions for the clock-source monitor: channel states, boolean
// constants and the select-index width helper.
package clock_mon_pkg;

  typedef enum logic [1:0] {
    LOST  = 2'b00,
    QUAL  = 2'b01,
    ALIVE = 2'b10
  } ch_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_mon_channel.sv
// One monitored clock domain: synchroniser, edge detect, watchdog, qualification
// counter, LOST/QUAL/ALIVE state machine and sticky loss flag.
module clock_mon_channel
  import clock_mon_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RECOVER = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_act,
  input  logic i_clr,
  output logic o_alive,
  output logic o_loss
);

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT);
  localparam logic [7:0] WD_TO  = 8'(TIMEOUT - 1);
  localparam logic [3:0] Q_MAX  = 4'(RECOVER);

  logic [2:0] r_sync;
  logic [7:0] r_wd;
  logic [3:0] r_qcnt;
  logic [3:0] w_qcnt_nxt;
  ch_state_e  r_state;
  ch_state_e  w_state_nxt;
  logic       r_alive;
  logic       r_loss;
  logic       w_edge;
  logic       w_timeout;
  logic       w_set_loss;

  // r_sync[1] is the second synchroniser flop, r_sync[2] its delayed copy
  assign w_edge    = r_sync[1] ^ r_sync[2];
  assign w_timeout = !w_edge && (r_wd == WD_TO);

  // Synchroniser shift and saturating edge-free watchdog
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 3'b000;
      r_wd   <= 8'd0;
    end else begin
      r_sync <= {r_sync[1:0], i_act};
      if (w_edge) begin
        r_wd <= 8'd0;
      end else if (r_wd != WD_MAX) begin
        r_wd <= r_wd + 8'd1;
      end
    end
  end

  // Next-state logic for the channel qualification FSM
  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_set_loss  = FALSE;
    case (r_state)
      LOST: begin
        if (w_edge && (Q_MAX <= 4'd1)) begin
          w_state_nxt = ALIVE;
          w_qcnt_nxt  = 4'd0;
        end else if (w_edge) begin
          w_state_nxt = QUAL;
          w_qcnt_nxt  = 4'd1;
        end else begin
          w_qcnt_nxt  = 4'd0;
        end
      end
      QUAL: begin
        if (w_edge && ((r_qcnt + 4'd1) >= Q_MAX)) begin
          w_state_nxt = ALIVE;
          w_qcnt_nxt  = 4'd0;
        end else if (w_edge) begin
          w_qcnt_nxt  = r_qcnt + 4'd1;
        end else if (w_timeout) begin
          w_state_nxt = LOST;
          w_qcnt_nxt  = 4'd0;
        end else begin
          w_qcnt_nxt  = r_qcnt;
        end
      end
      ALIVE: begin
        if (w_timeout) begin
          w_state_nxt = LOST;
          w_set_loss  = TRUE;
        end else begin
          w_state_nxt = ALIVE;
        end
      end
      default: begin
        w_state_nxt = LOST;
        w_qcnt_nxt  = 4'd0;
      end
    endcase
  end

  // State, counter and registered outputs; a loss in the same cycle as a clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LOST;
      r_qcnt  <= 4'd0;
      r_alive <= FALSE;
      r_loss  <= FALSE;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_alive <= (w_state_nxt == ALIVE);
      r_loss  <= w_set_loss | (r_loss & ~i_clr);
    end
  end

  assign o_alive = r_alive;
  assign o_loss  = r_loss;

endmodule

// File: rtl/clock_source_monitor.sv
// Multi-channel clock activity monitor with priority failover selection for a
// glitch-free clock mux; SEL_VALID=0 means run from MCLK_FPGA.
module clock_source_monitor
  import clock_mon_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT   = 16,
  parameter int RECOVER   = 4,
  parameter int REVERTIVE = 1,
  parameter int IDX_W     = idx_width(NUM_CH)
) (
  input  logic              MCLK_FPGA,
  input  logic              HARD_nRESETi,
  input  logic [NUM_CH-1:0] CH_ACT,
  input  logic [NUM_CH-1:0] CLR_FLAG,
  output logic [NUM_CH-1:0] CH_ALIVE,
  output logic [NUM_CH-1:0] LOSS_FLAG,
  output logic              SEL_VALID,
  output logic [IDX_W-1:0]  SEL_IDX,
  output logic              SEL_CHG
);

  logic [NUM_CH-1:0] w_alive;
  logic [NUM_CH-1:0] w_loss;
  logic [IDX_W-1:0]  w_low;
  logic              w_any;
  logic              w_keep;
  logic              w_valid_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              r_valid;
  logic [IDX_W-1:0]  r_idx;
  logic              r_chg;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_mon_channel #(
      .TIMEOUT (TIMEOUT),
      .RECOVER (RECOVER)
    ) u_ch (
      .i_clk   (MCLK_FPGA),
      .i_rst_n (HARD_nRESETi),
      .i_act   (CH_ACT[g]),
      .i_clr   (CLR_FLAG[g]),
      .o_alive (w_alive[g]),
      .o_loss  (w_loss[g])
    );
  end

  // Priority pick (lowest alive index) and revertive/non-revertive hold
  always_comb begin
    w_low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_low = w_alive[i] ? IDX_W'(i) : w_low;
    end
    w_any  = |w_alive;
    w_keep = (REVERTIVE == 0) && r_valid && w_alive[r_idx];
    if (w_keep) begin
      w_valid_nxt = TRUE;
      w_idx_nxt   = r_idx;
    end else if (w_any) begin
      w_valid_nxt = TRUE;
      w_idx_nxt   = w_low;
    end else begin
      w_valid_nxt = FALSE;
      w_idx_nxt   = r_idx;
    end
  end

  // Registered selection and its change pulse
  always_ff @(posedge MCLK_FPGA or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      r_valid <= FALSE;
      r_idx   <= '0;
      r_chg   <= FALSE;
    end else begin
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_chg   <= ({w_valid_nxt, w_idx_nxt} != {r_valid, r_idx});
    end
  end

  assign CH_ALIVE  = w_alive;
  assign LOSS_FLAG = w_loss;
  assign SEL_VALID = r_valid;
  assign SEL_IDX   = r_idx;
  assign SEL_CHG   = r_chg;

endmodule

// File: tb/tb_clock_source_monitor.sv
// Scoreboard bench: a revertive and a non-revertive monitor share stimulus and
// are checked every cycle against a behavioural model of the channel rules.
module tb_clock_source_monitor;

  localparam int NCH = 2;
  localparam int TMO = 16;
  localparam int REC = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] act   = '0;
  logic [NCH-1:0] clr   = '0;
  logic [NCH-1:0] alive_a, loss_a, alive_b, loss_b;
  logic           valid_a, chg_a, valid_b, chg_b;
  logic [0:0]     idx_a, idx_b;

  always #5 clk = ~clk;

  clock_source_monitor #(.NUM_CH(NCH), .TIMEOUT(TMO), .RECOVER(REC), .REVERTIVE(1)) dut_a (
    .MCLK_FPGA(clk), .HARD_nRESETi(rst_n), .CH_ACT(act), .CLR_FLAG(clr),
    .CH_ALIVE(alive_a), .LOSS_FLAG(loss_a), .SEL_VALID(valid_a), .SEL_IDX(idx_a), .SEL_CHG(chg_a));

  clock_source_monitor #(.NUM_CH(NCH), .TIMEOUT(TMO), .RECOVER(REC), .REVERTIVE(0)) dut_b (
    .MCLK_FPGA(clk), .HARD_nRESETi(rst_n), .CH_ACT(act), .CLR_FLAG(clr),
    .CH_ALIVE(alive_b), .LOSS_FLAG(loss_b), .SEL_VALID(valid_b), .SEL_IDX(idx_b), .SEL_CHG(chg_b));

  typedef struct {
    int alive;
    int loss;
    int v[2];
    int i[2];
    int c[2];
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // behavioural model: sampled input history, quiet-cycle count, edges seen, status
  int lvl[NCH][3];
  int silent[NCH];
  int run[NCH];
  bit m_alive[NCH];
  bit m_flag[NCH];
  bit sv[2];
  int si[2];
  bit sc[2];

  // stimulus generator state
  bit             gen_on[NCH];
  int             gen_cnt[NCH];
  int             gen_budget[NCH];
  int             clr_rate = 0;
  bit             collide  = 1'b0;
  logic [NCH-1:0] force_clr = '0;
  bit             rst_prev  = 1'b0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      for (int k = 0; k < 3; k++) lvl[i][k] = 0;
      silent[i] = 0; run[i] = 0; m_alive[i] = 1'b0; m_flag[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; si[k] = 0; sc[k] = 1'b0;
    end
  endtask

  // one MCLK rising edge of the reference behaviour
  task automatic model_step(input bit rstn, input logic [NCH-1:0] a, input logic [NCH-1:0] c);
    bit old_alive[NCH];
    bit e, set, any, keep, nv;
    int lowest, ni;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) old_alive[i] = m_alive[i];
    for (int i = 0; i < NCH; i++) begin
      e   = (lvl[i][1] != lvl[i][2]);
      set = 1'b0;
      lvl[i][2] = lvl[i][1];
      lvl[i][1] = lvl[i][0];
      lvl[i][0] = int'(a[i]);
      if (e) begin
        silent[i] = 0;
        if (!m_alive[i]) begin
          run[i]++;
          if (run[i] >= REC) begin
            m_alive[i] = 1'b1;
            run[i] = 0;
          end
        end
      end else begin
        if (silent[i] == TMO - 1) begin
          set = m_alive[i];
          m_alive[i] = 1'b0;
          run[i] = 0;
        end
        if (silent[i] < TMO) silent[i]++;
      end
      m_flag[i] = set || (m_flag[i] && !c[i]);
    end
    any = 1'b0; lowest = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (old_alive[i]) begin
        any = 1'b1; lowest = i;
      end
    end
    for (int k = 0; k < 2; k++) begin
      keep = (k == 1) && sv[k] && old_alive[si[k]];
      if (keep) begin
        nv = 1'b1; ni = si[k];
      end else if (any) begin
        nv = 1'b1; ni = lowest;
      end else begin
        nv = 1'b0; ni = si[k];
      end
      sc[k] = (nv != sv[k]) || (ni != si[k]);
      sv[k] = nv; si[k] = ni;
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.alive = 0; x.loss = 0;
    for (int i = 0; i < NCH; i++) begin
      x.alive |= int'(m_alive[i]) << i;
      x.loss  |= int'(m_flag[i]) << i;
    end
    for (int k = 0; k < 2; k++) begin
      x.v[k] = int'(sv[k]); x.i[k] = si[k]; x.c[k] = int'(sc[k]);
    end
    return x;
  endfunction

  // drive one cycle of inputs on the falling edge and queue the expected response
  task automatic cycle(input bit rstn);
    logic [NCH-1:0] c;
    @(negedge clk);
    c = force_clr;
    force_clr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gen_on[i] && gen_budget[i] != 0) begin
        if (gen_cnt[i] == 0) begin
          act[i] = ~act[i];
          gen_cnt[i] = $urandom_range(2, 6);
          if (gen_budget[i] > 0) gen_budget[i]--;
        end else begin
          gen_cnt[i]--;
        end
      end
      if (clr_rate > 0 && $urandom_range(1, clr_rate) == 1) c[i] = 1'b1;
      if (collide && m_alive[i] && lvl[i][1] == lvl[i][2] && silent[i] == TMO - 1) c[i] = 1'b1;
    end
    clr   = c;
    rst_n = rstn;
    if (!rstn && rst_prev) begin
      #1;
      check("reset_immediate",
            int'({alive_a, loss_a, valid_a, idx_a, chg_a, alive_b, loss_b, valid_b, idx_b, chg_b}), 0);
    end
    rst_prev = rstn;
    model_step(rstn, act, c);
    q.push_back(model_out());
  endtask

  task automatic set_gen(input int ch, input bit on, input int budget);
    gen_on[ch] = on; gen_budget[ch] = budget; gen_cnt[ch] = 0;
  endtask

  // monitor: pop one expectation per rising edge and compare both DUTs
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("ch_alive_a",  int'(alive_a), x.alive);
        check("loss_flag_a", int'(loss_a),  x.loss);
        check("ch_alive_b",  int'(alive_b), x.alive);
        check("loss_flag_b", int'(loss_b),  x.loss);
        check("sel_valid_rev", int'(valid_a), x.v[0]);
        check("sel_idx_rev",   int'(idx_a),   x.i[0]);
        check("sel_chg_rev",   int'(chg_a),   x.c[0]);
        check("sel_valid_nrv", int'(valid_b), x.v[1]);
        check("sel_idx_nrv",   int'(idx_b),   x.i[1]);
        check("sel_chg_nrv",   int'(chg_b),   x.c[1]);
      end
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < NCH; i++) set_gen(i, 1'b0, -1);
    repeat (3) cycle(1'b0);
    set_gen(0, 1'b1, -1);              repeat (40) cycle(1'b1);
    set_gen(0, 1'b0, -1);              repeat (30) cycle(1'b1);
    force_clr = 2'b01;                 repeat (5)  cycle(1'b1);
    set_gen(0, 1'b1, -1); set_gen(1, 1'b1, -1); repeat (50) cycle(1'b1);
    set_gen(0, 1'b0, -1);              repeat (30) cycle(1'b1);
    set_gen(0, 1'b1, -1);              repeat (40) cycle(1'b1);
    set_gen(0, 1'b0, -1);              repeat (30) cycle(1'b1);
    force_clr = 2'b01;                 repeat (3)  cycle(1'b1);
    set_gen(0, 1'b1, 3);               repeat (45) cycle(1'b1);
    set_gen(0, 1'b1, -1);              repeat (40) cycle(1'b1);
    collide = 1'b1; set_gen(0, 1'b0, -1); repeat (30) cycle(1'b1);
    collide = 1'b0;
    set_gen(0, 1'b1, -1);              repeat (40) cycle(1'b1);
    repeat (3) cycle(1'b0);
    repeat (40) cycle(1'b1);
    clr_rate = 30;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(1, 50) == 1)
          set_gen(i, !gen_on[i], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1);
      end
      if ($urandom_range(1, 40) == 1) collide = !collide;
      if ($urandom_range(1, 700) == 1) begin
        repeat ($urandom_range(1, 3)) cycle(1'b0);
      end else begin
        cycle(1'b1);
      end
    end
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
